// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver and held-key decoder for two players; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [4:0] P1_Keys,
  output logic [4:0] P2_Keys,
  output logic [7:0] Scan_Code_Out,
  output logic       Scan_Valid_Out,
  output logic       Frame_Error_Out
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic fclk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh;
  logic ext, brk, flip, smp, tout, ok, bad, pchk;
  assign flip = (clk_s[1] != fclk) && (fcnt == FMAX);
  assign smp = flip && fclk;
  assign tout = (state != IDLE) && (tcnt == TMAX);
`ifdef PS2_PARITY_CHECK_EN
  logic par;
  always_ff @(posedge Master_Clock_In or posedge Reset_In)
    if (Reset_In) par <= 1'b0;
    else if (smp && state == PARITY) par <= dat_s[1];
  assign pchk = ^{sh, par};
`else
  assign pchk = 1'b1;
`endif
  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      fclk  <= 1'b1;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DATA};
      fclk  <= flip ? clk_s[1] : fclk;
      fcnt  <= (clk_s[1] == fclk || flip) ? '0 : fcnt + 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    ok = 1'b0;
    bad = tout;
    if (tout) state_n = IDLE;
    else if (smp)
      case (state)
        IDLE:    state_n = dat_s[1] ? IDLE : DATA;
        DATA:    state_n = (bcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          ok = dat_s[1] && pchk;
          bad = !ok;
        end
      endcase
  end
  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      tcnt  <= (smp || state == IDLE) ? '0 : tcnt + 1'b1;
      bcnt  <= (smp && state == DATA) ? bcnt + 1'b1 : (state == IDLE ? 3'd0 : bcnt);
      if (smp && state == DATA) sh <= {dat_s[1], sh[7:1]};
    end
  end
  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      P1_Keys         <= '0;
      P2_Keys         <= '0;
      Scan_Code_Out   <= '0;
      Scan_Valid_Out  <= 1'b0;
      Frame_Error_Out <= 1'b0;
      ext             <= 1'b0;
      brk             <= 1'b0;
    end else begin
      Scan_Valid_Out  <= ok;
      Frame_Error_Out <= bad;
      if (bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (ok) begin
        Scan_Code_Out <= sh;
        if (sh == 8'hE0) ext <= 1'b1;
        else if (sh == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          case ({ext, sh})
            9'h01D:  P1_Keys[0] <= !brk;
            9'h01C:  P1_Keys[1] <= !brk;
            9'h023:  P1_Keys[2] <= !brk;
            9'h01B:  P1_Keys[3] <= !brk;
            9'h029:  P1_Keys[4] <= !brk;
            9'h05A:  P2_Keys[4] <= !brk;
            9'h175:  P2_Keys[0] <= !brk;
            9'h16B:  P2_Keys[1] <= !brk;
            9'h174:  P2_Keys[2] <= !brk;
            9'h172:  P2_Keys[3] <= !brk;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames against a byte-level key-state model
module tb_ps2_key_decoder;
  localparam int H = 40;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk = 0, rst = 0, ps2c = 1, ps2d = 1;
  logic [4:0] p1, p2;
  logic [7:0] code;
  logic valid, ferr;
  int nchk = 0, nerr = 0, nv = 0, ne = 0;
  bit quiet = 0;
  logic [4:0] e_p1 = 0, e_p2 = 0;
  bit m_ext = 0, m_brk = 0;
  ps2_key_decoder dut (
    .Master_Clock_In(clk), .Reset_In(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d),
    .P1_Keys(p1), .P2_Keys(p2), .Scan_Code_Out(code),
    .Scan_Valid_Out(valid), .Frame_Error_Out(ferr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  function automatic void model_byte(input logic [7:0] b);
    int idx;
    idx = -1;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext) idx = (b == 8'h1D) ? 0 : (b == 8'h1C) ? 1 : (b == 8'h23) ? 2 :
                        (b == 8'h1B) ? 3 : (b == 8'h29) ? 4 : (b == 8'h5A) ? 9 : -1;
      else idx = (b == 8'h75) ? 5 : (b == 8'h6B) ? 6 : (b == 8'h74) ? 7 : (b == 8'h72) ? 8 : -1;
      if (idx >= 0 && idx < 5) e_p1[idx] = !m_brk;
      else if (idx >= 5) e_p2[idx-5] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction
  function automatic logic [10:0] mk(input logic [7:0] b, input bit badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      repeat (H) @(posedge clk);
      ps2c = 0;
      repeat (H) @(posedge clk);
      ps2c = 1;
    end
    ps2d = 1;
  endtask
  task automatic frame(input logic [7:0] b, input bit badpar = 0);
    quiet = 0;
    nv = 0;
    ne = 0;
    send_bits(mk(b, badpar), 11);
    repeat (30) @(posedge clk);
    if (!badpar || !PCHK) begin
      chk("valid_cnt", nv, 1);
      chk("err_cnt", ne, 0);
      chk("code", code, b);
      model_byte(b);
    end else begin
      chk("valid_cnt", nv, 0);
      chk("err_cnt", ne, 1);
      m_ext = 0;
      m_brk = 0;
    end
    quiet = 1;
    repeat (4) @(posedge clk);
  endtask
  always @(negedge clk) begin
    if (valid) nv++;
    if (ferr) ne++;
    chk("exclusive", {31'd0, valid & ferr}, 0);
    if (quiet) begin
      chk("p1", {27'd0, p1}, {27'd0, e_p1});
      chk("p2", {27'd0, p2}, {27'd0, e_p2});
    end
  end
  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_p1", p1, 0);
    chk("rst_p2", p2, 0);
    chk("rst_code", code, 0);
    chk("rst_pulses", {valid, ferr}, 0);
    quiet = 1;
    frame(8'h1D);
    chk("w_make", p1, 5'b00001);
    frame(8'hF0); frame(8'h1D);
    chk("w_break", p1, 5'b00000);
    frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'h6B);
    chk("p2_ul", p2, 5'b00011);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("p2_l", p2, 5'b00010);
    frame(8'hE0); frame(8'hF0); frame(8'h6B);
    frame(8'h75); frame(8'hE0); frame(8'h5A);
    chk("mismatch", p2, 5'b00000);
    frame(8'h1C); frame(8'h1C);
    chk("typematic", p1, 5'b00010);
    frame(8'h23); frame(8'hF0); frame(8'h1C); frame(8'hAA); frame(8'hFA); frame(8'hFE);
    chk("indep", p1, 5'b00100);
    frame(8'hF0); frame(8'h23);
    frame(8'h29, 1);
    chk("badpar", p1[4], PCHK ? 1'b0 : 1'b1);
    frame(8'hF0); frame(8'h29);
    frame(8'hF0);
    quiet = 0;
    nv = 0;
    ne = 0;
    send_bits(mk(8'h55, 0), 5);
    quiet = 1;
    repeat (30000) @(posedge clk);
    chk("tout_err", ne, 1);
    chk("tout_valid", nv, 0);
    m_ext = 0;
    m_brk = 0;
    frame(8'h1B);
    chk("after_tout", p1, 5'b01000);
    ps2d = 0;
    nv = 0;
    ne = 0;
    for (int i = 0; i < 6; i++) begin
      ps2c = 0;
      repeat (3) @(posedge clk);
      ps2c = 1;
      repeat (12) @(posedge clk);
    end
    ps2d = 1;
    repeat (50) @(posedge clk);
    chk("glitch_pulses", nv + ne, 0);
    frame(8'h1D);
    chk("after_glitch", p1, 5'b01001);
    quiet = 0;
    send_bits(mk(8'h29, 0), 6);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst", {p1, p2, code, valid, ferr}, 0);
    rst = 0;
    e_p1 = 0;
    e_p2 = 0;
    m_ext = 0;
    m_brk = 0;
    repeat (5) @(posedge clk);
    quiet = 1;
    frame(8'h1D);
    chk("post_rst", p1, 5'b00001);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
